// File: rtl/phy_pkg.sv
// Shared PHY constants and receiver FSM encoding, common to the transmitter and receiver.
package phy_pkg;

  localparam logic [7:0] COMMA_DEFAULT      = 8'hBC;
  localparam int         SYNC_COUNT_DEFAULT = 4;
  localparam int         NUM_LANES          = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } rx_state_e;

  function automatic logic is_comma(input logic [7:0] b, input logic [7:0] comma);
    return (b == comma);
  endfunction

endpackage

// File: rtl/rx_byte_aligner.sv
// Serial-to-byte aligner: hunts for the comma, confirms byte lock over SYNC_COUNT
// aligned commas, then emits one strobed byte per 8 serial bits.
module rx_byte_aligner
  import phy_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_DEFAULT,
  parameter int         SYNC_COUNT = SYNC_COUNT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] byte_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam int             CW        = (SYNC_COUNT < 2) ? 1 : $clog2(SYNC_COUNT + 1);
  localparam logic [CW-1:0]  SYNC_LAST = CW'(SYNC_COUNT - 1);

  rx_state_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          strobe_q, strobe_d;
  logic          active_q, active_d;
  logic          boundary;
  logic          match;

  // Decisions look at shift_d so a byte is judged on the edge that samples its last bit.
  always_comb begin
    shift_d     = {shift_q[6:0], serial_in};
    bit_cnt_d   = bit_cnt_q + 3'd1;
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    byte_d      = byte_q;
    strobe_d    = 1'b0;
    active_d    = active_q;
    boundary    = (bit_cnt_q == 3'd7);
    match       = is_comma(shift_d, COMMA);

    case (state_q)
      ST_SEARCH: begin
        if (match) begin
          bit_cnt_d   = 3'd0;
          comma_cnt_d = CW'(1);
          if (SYNC_COUNT <= 1) begin
            state_d  = ST_ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ST_ALIGN;
          end
        end
      end
      ST_ALIGN: begin
        if (boundary) begin
          if (match) begin
            comma_cnt_d = comma_cnt_q + CW'(1);
            if (comma_cnt_q == SYNC_LAST) begin
              state_d  = ST_ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            state_d     = ST_SEARCH;
            comma_cnt_d = '0;
          end
        end
      end
      ST_ACTIVE: begin
        if (boundary) begin
          byte_d   = shift_d;
          strobe_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SEARCH;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      byte_q      <= '0;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      byte_q      <= byte_d;
      strobe_q    <= strobe_d;
      active_q    <= active_d;
    end
  end

  assign byte_out    = byte_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule

// File: rtl/phy_rx_deserializer.sv
// Four-lane PHY receiver: byte aligner plus lane demux; all four lane outputs
// change together once per 32-bit frame.
module phy_rx_deserializer
  import phy_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_DEFAULT,
  parameter int         SYNC_COUNT = SYNC_COUNT_DEFAULT
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       in_from_tx,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic [7:0] data_out2,
  output logic [7:0] data_out3,
  output logic       valid_out0,
  output logic       valid_out1,
  output logic       valid_out2,
  output logic       valid_out3,
  output logic       active
);

  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       rx_active;
  logic       byte_is_data;

  logic [1:0] lane_cnt_q, lane_cnt_d;
  logic [7:0] stage_data_q [3];
  logic [7:0] stage_data_d [3];
  logic [2:0] stage_valid_q, stage_valid_d;
  logic [7:0] data_q [NUM_LANES];
  logic [7:0] data_d [NUM_LANES];
  logic [NUM_LANES-1:0] valid_q, valid_d;

  rx_byte_aligner #(
    .COMMA      (COMMA),
    .SYNC_COUNT (SYNC_COUNT)
  ) u_align (
    .clk         (clk_32f),
    .rst         (reset),
    .serial_in   (in_from_tx),
    .byte_out    (rx_byte),
    .byte_strobe (rx_strobe),
    .active      (rx_active)
  );

  // Lanes 0..2 park in staging; the lane-3 byte commits the whole frame at once.
  // Staging only takes non-comma bytes, so a comma lane keeps its previous data.
  always_comb begin
    lane_cnt_d    = lane_cnt_q;
    stage_data_d  = stage_data_q;
    stage_valid_d = stage_valid_q;
    data_d        = data_q;
    valid_d       = valid_q;
    byte_is_data  = !is_comma(rx_byte, COMMA);

    if (!rx_active) begin
      lane_cnt_d = '0;
    end else if (rx_strobe) begin
      lane_cnt_d = lane_cnt_q + 2'd1;
      if (lane_cnt_q == 2'd3) begin
        for (int i = 0; i < 3; i++) begin
          data_d[i]  = stage_data_q[i];
          valid_d[i] = stage_valid_q[i];
        end
        valid_d[3] = byte_is_data;
        if (byte_is_data) begin
          data_d[3] = rx_byte;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (lane_cnt_q == 2'(i)) begin
            stage_valid_d[i] = byte_is_data;
            if (byte_is_data) begin
              stage_data_d[i] = rx_byte;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      lane_cnt_q    <= '0;
      stage_valid_q <= '0;
      valid_q       <= '0;
      for (int i = 0; i < 3; i++) begin
        stage_data_q[i] <= '0;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      lane_cnt_q    <= lane_cnt_d;
      stage_valid_q <= stage_valid_d;
      valid_q       <= valid_d;
      stage_data_q  <= stage_data_d;
      data_q        <= data_d;
    end
  end

  assign data_out0  = data_q[0];
  assign data_out1  = data_q[1];
  assign data_out2  = data_q[2];
  assign data_out3  = data_q[3];
  assign valid_out0 = valid_q[0];
  assign valid_out1 = valid_q[1];
  assign valid_out2 = valid_q[2];
  assign valid_out3 = valid_q[3];
  assign active     = rx_active;

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Directed bench for phy_rx_deserializer: sync acquisition, frame table, async reset.
module tb_phy_rx_deserializer;
  import phy_pkg::*;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       in_from_tx;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic       valid_out0, valid_out1, valid_out2, valid_out3;
  logic       active;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0][7:0] bytes;
    logic [3:0][7:0] data;
    logic [3:0]      valid;
  } vec_t;

  logic [3:0][7:0] exp_data;
  logic [3:0]      exp_valid;
  logic            exp_active;
  logic [3:0][7:0] pend_data;
  logic [3:0]      pend_valid;
  bit              apply_pending;
  bit              chk_en;
  vec_t            vecs [4];

  phy_rx_deserializer dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .in_from_tx (in_from_tx),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .data_out2  (data_out2),
    .data_out3  (data_out3),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .valid_out2 (valid_out2),
    .valid_out3 (valid_out3),
    .active     (active)
  );

  always #5 clk_32f = ~clk_32f;

  function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3,
                              input logic [7:0] d0, d1, d2, d3,
                              input logic [3:0] v);
    vec_t r;
    r.bytes = {b3, b2, b1, b0};
    r.data  = {d3, d2, d1, d0};
    r.valid = v;
    return r;
  endfunction

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string name);
    logic [36:0] act, exp;
    act = {data_out3, data_out2, data_out1, data_out0,
           valid_out3, valid_out2, valid_out1, valid_out0, active};
    exp = {exp_data[3], exp_data[2], exp_data[1], exp_data[0], exp_valid, exp_active};
    check_val(name, 64'(act), 64'(exp));
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    in_from_tx = b;
    @(posedge clk_32f);
    #1;
  endtask

  // Pending frame results become visible on the first bit edge of the following byte.
  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      if (i == 7 && apply_pending) begin
        exp_data      = pend_data;
        exp_valid     = pend_valid;
        apply_pending = 0;
      end
      if (chk_en) check_outputs("frame_outputs");
    end
  endtask

  task automatic send_frame(input logic [3:0][7:0] b);
    for (int k = 0; k < 4; k++) send_byte(b[k]);
  endtask

  task automatic sync4_check(input string name);
    logic [7:0] c;
    c = COMMA_DEFAULT;
    for (int k = 0; k < 3; k++) begin
      send_byte(c);
      check_val({name, "_early"}, 64'(active), 64'(0));
    end
    for (int i = 7; i >= 1; i--) send_bit(c[i]);
    check_val({name, "_before_last"}, 64'(active), 64'(0));
    send_bit(c[0]);
    check_val(name, 64'(active), 64'(1));
  endtask

  initial begin
    vecs[0] = mk(8'hCC, 8'hFD, 8'hAA, 8'h12,  8'hCC, 8'hFD, 8'hAA, 8'h12, 4'b1111);
    vecs[1] = mk(8'h00, 8'hBC, 8'hEE, 8'hBC,  8'h00, 8'hFD, 8'hEE, 8'h12, 4'b0101);
    vecs[2] = mk(8'h5A, 8'hBC, 8'hBC, 8'h01,  8'h5A, 8'hFD, 8'hEE, 8'h01, 4'b1001);
    vecs[3] = mk(8'hBC, 8'hBC, 8'hBC, 8'hBC,  8'h5A, 8'hFD, 8'hEE, 8'h01, 4'b0000);

    reset         = 1'b1;
    in_from_tx    = 1'b0;
    chk_en        = 0;
    apply_pending = 0;
    exp_data      = '0;
    exp_valid     = '0;
    exp_active    = 1'b0;

    repeat (3) @(posedge clk_32f);
    #1;
    check_outputs("reset_state");
    @(negedge clk_32f);
    reset = 1'b0;
    @(posedge clk_32f);
    #1;
    check_outputs("post_reset_idle");

    // Three commas then a data byte: lock must be abandoned.
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    send_byte(8'h55);
    check_val("fail_sync_active", 64'(active), 64'(0));
    check_val("fail_sync_state", 64'(dut.u_align.state_q), 64'(ST_SEARCH));
    sync4_check("resync_after_fail");

    // Fresh start with misaligning garbage bits.
    @(negedge clk_32f);
    reset = 1'b1;
    @(negedge clk_32f);
    reset = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    sync4_check("sync_active");

    exp_data   = '0;
    exp_valid  = '0;
    exp_active = 1'b1;
    chk_en     = 1;
    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].bytes);
      pend_data     = vecs[v].data;
      pend_valid    = vecs[v].valid;
      apply_pending = 1;
    end

    // Partial frame (lanes 0, 1 and half of lane 2) cut short by reset.
    send_byte(8'h77);
    send_byte(8'h88);
    for (int i = 7; i >= 4; i--) begin
      send_bit(1'b1);
      check_outputs("partial_frame_hold");
    end
    chk_en = 0;
    #2;
    reset = 1'b1;
    #1;
    exp_data   = '0;
    exp_valid  = '0;
    exp_active = 1'b0;
    check_outputs("async_reset");
    @(negedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b0;
    sync4_check("sync_after_reset");

    exp_active = 1'b1;
    chk_en     = 1;
    send_frame({8'h44, 8'h33, 8'h22, 8'h11});
    pend_data     = {8'h44, 8'h33, 8'h22, 8'h11};
    pend_valid    = 4'b1111;
    apply_pending = 1;
    send_frame({8'hBC, 8'hBC, 8'hBC, 8'hBC});
    chk_en = 0;
    check_val("final_data3", 64'(data_out3), 64'(8'h44));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phy_rx_deserializer.md
PHY_RX_DESERIALIZER -- requirements
Module: phy_rx_deserializer

Interface
REQ-001 Parameter COMMA, default 8'hBC: control byte sent by the transmitter for an invalid lane and used as the alignment comma.
REQ-002 Parameter SYNC_COUNT, default 4: number of consecutive byte-aligned COMMA bytes needed to declare sync.
REQ-003 clk_32f  input  1  single clock; one serial bit is sampled per rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_from_tx  input  1  serial line from the transmitter, MSB of each byte first.
REQ-006 data_out0..data_out3  output  8 each  recovered lane bytes, registered.
REQ-007 valid_out0..valid_out3  output  1 each  lane byte valid, registered.
REQ-008 active  output  1  high while the receiver is byte- and frame-aligned.

Function
REQ-009 The block SHALL shift in_from_tx into an 8-bit shift register on every clk_32f rising edge, with the new bit entering at the LSB.
REQ-010 The FSM SHALL have three states: SEARCH, ALIGN and ACTIVE.
REQ-011 SEARCH: the block SHALL compare the shift register with COMMA on every edge; on a match it SHALL set the bit counter to 0, set comma_cnt to 1 and enter ALIGN.
REQ-012 ALIGN: at each byte boundary (bit counter wraps 7->0), a COMMA byte SHALL increment comma_cnt, and a non-COMMA byte SHALL return the FSM to SEARCH with comma_cnt cleared.
REQ-013 When comma_cnt reaches SYNC_COUNT, the block SHALL enter ACTIVE, set active=1 on the same edge, and clear the lane counter to 0; the next byte is lane 0.
REQ-014 ACTIVE: each completed byte SHALL be stored in lane slot lane_cnt; lane_cnt SHALL then increment modulo 4 (3->0 wraps).
REQ-015 Stored valid for a lane SHALL be 1 if the byte differs from COMMA, else 0; a COMMA byte SHALL leave that lane's stored data unchanged.
REQ-016 When the lane-3 byte completes (edge N), data_out0..3 and valid_out0..3 SHALL all update together at edge N+1 and hold for 32 cycles until the next frame update.
REQ-017 ACTIVE SHALL persist until reset; there is no loss-of-sync detection in this revision.
REQ-018 A frame of four COMMA bytes SHALL drive valid_out0..3 to 0 while keeping the previous data_out values.
REQ-019 The block SHALL emit no output update in SEARCH or ALIGN, and active SHALL be 0 in those states.

Reset
REQ-020 While reset=1, asynchronously: state=SEARCH, shift register=0, bit/comma/lane counters=0, data_out0..3=8'h00, valid_out0..3=0, active=0.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame; after release, sync is reacquired from SEARCH.

Structure
REQ-022 The shared package phy_pkg SHALL hold the COMMA default, the SYNC_COUNT default and the FSM state encoding, so the transmitter uses the same values.
REQ-023 One sub-module, rx_byte_aligner, SHALL contain the shift register, comma detection, bit counter and SEARCH/ALIGN/ACTIVE FSM, and provide byte, byte_strobe and active.
REQ-024 Lane demux and output registers SHALL stay in the top module.

Verification
REQ-025 Reset: assert reset mid-run -> all outputs 0 immediately, without waiting for a clock edge.
REQ-026 Sync: 3 garbage bits 101, then four BC bytes -> active=1 on the edge that samples the last bit of the 4th BC.
REQ-027 Failed sync: BC BC BC 55 -> active stays 0 and the FSM is back in SEARCH; four more BC -> active=1.
REQ-028 Data frame after sync: bytes CC FD AA 12 -> one cycle after the last bit: data_out0..3=CC,FD,AA,12 and valid_out0..3=1111, held 32 cycles.
REQ-029 Mixed frame: bytes 00 BC EE BC after REQ-028 -> data_out=00,FD,EE,12 and valid=1,0,1,0.
REQ-030 Reset during the lane-2 byte, then four BC plus frame 11 22 33 44 -> no output from the partial frame, then 11,22,33,44 valid=1111.
